// File: rtl/window_rom_arbiter.sv
// window_rom_arbiter
//   Shares one single-port image ROM between two 3x3 window filter engines
//   (requester 0 = Sobel, requester 1 = Gaussian). Each grant issues a
//   9-read burst in column-major kernel order starting at the requester's
//   top-left pixel address. Returned ROM data is tagged with its owner and
//   kernel phase.
//
//   Parameters
//     IMG_W    image row pitch in pixels
//     ADDR_W   ROM address width
//     DATA_W   pixel width
//     ROM_LAT  ROM read latency in cycles (1..4)
//
//   Ports
//     clk, rst                  clock, synchronous active-high reset
//     req0/req1, base0/base1    burst requests (level) and window base addresses
//     gnt0/gnt1                 high for the 9 issue cycles of a burst
//     rom_en, rom_addr          ROM read strobe and address
//     rom_data                  ROM read data (ROM_LAT cycles after rom_en)
//     rd_valid0/rd_valid1       rd_data belongs to requester 0 / 1
//     rd_data, rd_idx           returned pixel and its kernel phase 0..8
//     burst_done0/burst_done1   pulse with the phase-8 rd_valid
//     busy                      burst issuing or its data still in flight
//
//   Build option
//     ARB_FIXED_PRIO_EN  when defined, requester 0 always wins ties and no
//                        round-robin pointer exists.
module window_rom_arbiter #(
    parameter int IMG_W   = 32,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] base0,
    input  logic [ADDR_W-1:0] base1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              rd_valid0,
    output logic              rd_valid1,
    output logic [DATA_W-1:0] rd_data,
    output logic [3:0]        rd_idx,
    output logic              burst_done0,
    output logic              burst_done1,
    output logic              busy
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state, state_nx;
    logic [3:0]        ph, ph_nx;
    logic              owner, owner_nx;
    logic [ADDR_W-1:0] base_q, base_nx;
    logic              win;

    // Issue-stage tag registers travelling alongside rom_en/rom_addr
    logic [3:0]        iss_ph;

    // Return shift register, stage ROM_LAT lines up with rom_data
    logic [ROM_LAT:1]       ret_v;
    logic [ROM_LAT:1]       ret_own;
    logic [ROM_LAT:1][3:0]  ret_ph;

    // Kernel offset for phase p: column-major walk over the 3x3 window
    function automatic logic [ADDR_W-1:0] phase_offset(input logic [3:0] p);
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
        row = ADDR_W'(p % 4'd3);
        col = ADDR_W'(p / 4'd3);
        return row * ADDR_W'(IMG_W) + col;
    endfunction

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        win = ~req0;
    end
`else
    // Last-served pointer; resets to 1 so requester 0 takes the first tie.
    // An owner re-requesting at phase 8 is the last served, so a waiting
    // peer wins.
    logic last, last_nx;

    always_comb begin
        win = (req0 && req1) ? ~last : req1;
    end
`endif

    always_comb begin
        state_nx = state;
        ph_nx    = ph;
        owner_nx = owner;
        base_nx  = base_q;
`ifndef ARB_FIXED_PRIO_EN
        last_nx  = last;
`endif
        // Arbitration slot: idle, or the last issue cycle of a burst so the
        // next burst follows with no gap.
        if (state == IDLE || ph == 4'd8) begin
            if (req0 || req1) begin
                state_nx = ISSUE;
                ph_nx    = 4'd0;
                owner_nx = win;
                base_nx  = win ? base1 : base0;
`ifndef ARB_FIXED_PRIO_EN
                last_nx  = win;
`endif
            end else begin
                state_nx = IDLE;
                ph_nx    = 4'd0;
            end
        end else begin
            ph_nx = ph + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ph     <= 4'd0;
            owner  <= 1'b0;
            base_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last   <= 1'b1;
`endif
        end else begin
            state  <= state_nx;
            ph     <= ph_nx;
            owner  <= owner_nx;
            base_q <= base_nx;
`ifndef ARB_FIXED_PRIO_EN
            last   <= last_nx;
`endif
        end
    end

    // Registered issue outputs, one cycle behind the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            iss_ph   <= 4'd0;
        end else begin
            gnt0     <= (state == ISSUE) && !owner;
            gnt1     <= (state == ISSUE) && owner;
            rom_en   <= (state == ISSUE);
            rom_addr <= (state == ISSUE) ? base_q + phase_offset(ph) : '0;
            iss_ph   <= (state == ISSUE) ? ph : 4'd0;
        end
    end

    // Return path; cleared on reset so in-flight reads are discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_v   <= '0;
            ret_own <= '0;
            ret_ph  <= '0;
        end else begin
            ret_v[1]   <= rom_en;
            ret_own[1] <= gnt1;
            ret_ph[1]  <= iss_ph;
            for (int i = 2; i <= ROM_LAT; i++) begin
                ret_v[i]   <= ret_v[i-1];
                ret_own[i] <= ret_own[i-1];
                ret_ph[i]  <= ret_ph[i-1];
            end
        end
    end

    assign rd_data     = rom_data;
    assign rd_valid0   = ret_v[ROM_LAT] & ~ret_own[ROM_LAT];
    assign rd_valid1   = ret_v[ROM_LAT] &  ret_own[ROM_LAT];
    assign rd_idx      = ret_ph[ROM_LAT];
    assign burst_done0 = rd_valid0 && (ret_ph[ROM_LAT] == 4'd8);
    assign burst_done1 = rd_valid1 && (ret_ph[ROM_LAT] == 4'd8);
    assign busy        = (state == ISSUE) || rom_en || (|ret_v);

endmodule

// File: tb/tb_window_rom_arbiter.sv
module tb_window_rom_arbiter;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int IW = 32;

    typedef struct packed {
        logic          v;
        logic          own;
        logic [3:0]    ph;
        logic [AW-1:0] addr;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] base0 = '0, base1 = '0;

    // Instance a: ROM_LAT = 1
    logic a_g0, a_g1, a_en, a_v0, a_v1, a_d0, a_d1, a_busy;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_rom, a_data;
    logic [3:0]    a_idx;
    // Instance b: ROM_LAT = 3
    logic b_g0, b_g1, b_en, b_v0, b_v1, b_d0, b_d1, b_busy;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_rom, b_data, b_s1, b_s2;
    logic [3:0]    b_idx;

    always #5 clk = ~clk;

    window_rom_arbiter #(.IMG_W(IW), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) u_a (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .base0(base0), .base1(base1),
        .gnt0(a_g0), .gnt1(a_g1), .rom_en(a_en), .rom_addr(a_addr), .rom_data(a_rom),
        .rd_valid0(a_v0), .rd_valid1(a_v1), .rd_data(a_data), .rd_idx(a_idx),
        .burst_done0(a_d0), .burst_done1(a_d1), .busy(a_busy));

    window_rom_arbiter #(.IMG_W(IW), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) u_b (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .base0(base0), .base1(base1),
        .gnt0(b_g0), .gnt1(b_g1), .rom_en(b_en), .rom_addr(b_addr), .rom_data(b_rom),
        .rd_valid0(b_v0), .rd_valid1(b_v1), .rd_data(b_data), .rd_idx(b_idx),
        .burst_done0(b_d0), .burst_done1(b_d1), .busy(b_busy));

    // ROM contents: a fixed scramble of the address
    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return a[7:0] ^ {a[9:8], 6'h15};
    endfunction

    always @(posedge clk) begin
        a_rom <= rom_f(a_addr);
        b_s1  <= rom_f(b_addr);
        b_s2  <= b_s1;
        b_rom <= b_s2;
    end

    // Reference model state
    int   n_asrt = 0, n_fail = 0;
    int   cyc = 0, next_arb = 0, last_rst = 0;
    logic last_srv = 1'b1;
    ent_t exp_tab [int];
    bit   want0 = 0, want1 = 0, hold0 = 0, hold1 = 0;

    function automatic ent_t lk(input int k);
        if (exp_tab.exists(k)) return exp_tab[k];
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Edge n: who gets the ROM, and which 9 addresses follow
    task automatic model_edge(input int n);
        logic w;
        int   b;
        ent_t e;
        if (rst) begin
            for (int k = n; k <= n + 10; k++)
                if (exp_tab.exists(k)) exp_tab.delete(k);
            last_rst = n;
            next_arb = n + 1;
            last_srv = 1'b1;
        end else if (n == next_arb) begin
            if (req0 || req1) begin
                if (req0 && !req1) w = 1'b0;
                else if (req1 && !req0) w = 1'b1;
                else begin
`ifdef ARB_FIXED_PRIO_EN
                    w = 1'b0;
`else
                    w = (last_srv == 1'b1) ? 1'b0 : 1'b1;
`endif
                end
                last_srv = w;
                b = w ? int'(base1) : int'(base0);
                for (int p = 0; p < 9; p++) begin
                    e.v    = 1'b1;
                    e.own  = w;
                    e.ph   = 4'(p);
                    e.addr = AW'((b + (p % 3) * IW + p / 3) % 1024);
                    exp_tab[n + 1 + p] = e;
                end
                next_arb = n + 9;
            end else begin
                next_arb = n + 1;
            end
        end
    endtask

    task automatic chk_inst(input string nm, input int L, input int c,
                            input logic g0, input logic g1, input logic en,
                            input logic [AW-1:0] ad, input logic v0, input logic v1,
                            input logic [3:0] ix, input logic d0, input logic d1,
                            input logic [DW-1:0] dt, input logic bz);
        ent_t e, r, q;
        logic alive, bexp;
        e = lk(c);
        chk($sformatf("%s c%0d gnt0", nm, c), 32'(g0), 32'(e.v & ~e.own));
        chk($sformatf("%s c%0d gnt1", nm, c), 32'(g1), 32'(e.v & e.own));
        chk($sformatf("%s c%0d rom_en", nm, c), 32'(en), 32'(e.v));
        if (e.v) chk($sformatf("%s c%0d rom_addr", nm, c), 32'(ad), 32'(e.addr));
        if (c == last_rst) begin
            chk($sformatf("%s c%0d rst rom_addr", nm, c), 32'(ad), 32'd0);
            chk($sformatf("%s c%0d rst rd_idx", nm, c), 32'(ix), 32'd0);
        end
        r = lk(c - L);
        alive = r.v && (c - L >= last_rst);
        chk($sformatf("%s c%0d rd_valid0", nm, c), 32'(v0), 32'(alive & ~r.own));
        chk($sformatf("%s c%0d rd_valid1", nm, c), 32'(v1), 32'(alive & r.own));
        chk($sformatf("%s c%0d burst_done0", nm, c), 32'(d0), 32'(alive && !r.own && r.ph == 4'd8));
        chk($sformatf("%s c%0d burst_done1", nm, c), 32'(d1), 32'(alive && r.own && r.ph == 4'd8));
        if (alive) begin
            chk($sformatf("%s c%0d rd_idx", nm, c), 32'(ix), 32'(r.ph));
            chk($sformatf("%s c%0d rd_data", nm, c), 32'(dt), 32'(rom_f(r.addr)));
        end
        bexp = lk(c + 1).v;
        for (int k = c - L; k <= c; k++) begin
            q = lk(k);
            if (q.v && k >= last_rst) bexp = 1'b1;
        end
        chk($sformatf("%s c%0d busy", nm, c), 32'(bz), 32'(bexp));
    endtask

    task automatic tick();
        ent_t e;
        req0 = want0;
        req1 = want1;
        model_edge(cyc + 1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk_inst("lat1", 1, cyc, a_g0, a_g1, a_en, a_addr, a_v0, a_v1, a_idx, a_d0, a_d1, a_data, a_busy);
        chk_inst("lat3", 3, cyc, b_g0, b_g1, b_en, b_addr, b_v0, b_v1, b_idx, b_d0, b_d1, b_data, b_busy);
        // A requester lets go once it has seen its grant
        e = lk(cyc);
        if (e.v && e.ph == 4'd0) begin
            if (!e.own && !hold0) want0 = 0;
            if (e.own && !hold1) want1 = 0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [AW-1:0] rnd_base();
        return AW'($urandom_range(0, 29) * IW + $urandom_range(0, 29));
    endfunction

    initial begin
        // Reset
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(2);

        // Single burst from requester 0 at base 0
        base0 = 10'd0; want0 = 1;
        ticks(20);

        // Simultaneous requests, bases 0 and 29
        base0 = 10'd0; base1 = 10'd29; want0 = 1; want1 = 1;
        ticks(26);

        // Both held for six bursts
        hold0 = 1; hold1 = 1; want0 = 1; want1 = 1;
        ticks(54);
        hold0 = 0; hold1 = 0; want0 = 0; want1 = 0;
        ticks(14);

        // Address wrap
        base0 = 10'd1000; want0 = 1;
        ticks(20);

        // Reset in the middle of a burst (phase 4 on the issue side)
        base0 = 10'd5; want0 = 1;
        ticks(6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ticks(12);
        base0 = 10'd100; want0 = 1;
        ticks(16);

        // Requester 1 pulses once while requester 0 is issuing
        base0 = 10'd40; want0 = 1;
        ticks(3);
        base1 = 10'd300; want1 = 1;
        tick();
        want1 = 0;
        ticks(16);

        // Randomised traffic with withdrawals and occasional resets
        for (int i = 0; i < 700; i++) begin
            if (!want0 && $urandom_range(0, 3) == 0) begin want0 = 1; base0 = rnd_base(); end
            if (!want1 && $urandom_range(0, 3) == 0) begin want1 = 1; base1 = rnd_base(); end
            if (want0 && $urandom_range(0, 40) == 0) want0 = 0;
            if (want1 && $urandom_range(0, 40) == 0) want1 = 0;
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0; want0 = 0; want1 = 0;
        ticks(16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
